// File: rtl/ip_tile_regbank.sv
// Host register bank feeding the user IP tile: operand/command registers out, result/status capture in.
// Optional pending-command timeout is built only when IP_TILE_REGBANK_TIMEOUT_EN is defined.
module ip_tile_regbank #(
    parameter int REG_WIDTH      = 32,
    parameter int CSR_IN_WIDTH   = 16,
    parameter int CSR_OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     host_we,
    input  logic                     host_re,
    input  logic [ADDR_WIDTH-1:0]    host_addr,
    input  logic [REG_WIDTH-1:0]     host_wdata,
    output logic [REG_WIDTH-1:0]     host_rdata,
    output logic                     host_rvalid,
    output logic [REG_WIDTH-1:0]     data_reg_a,
    output logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic                     csr_in_re,
    input  logic [REG_WIDTH-1:0]     data_reg_c,
    input  logic [CSR_OUT_WIDTH-1:0] csr_out,
    input  logic                     csr_out_we,
    output logic                     irq
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_A  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_B  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_C  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CSR_IN  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CSR_OUT = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_EN  = ADDR_WIDTH'(6);

    if (CSR_IN_WIDTH > REG_WIDTH || CSR_OUT_WIDTH > REG_WIDTH || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("ip_tile_regbank: illegal parameter combination");
    end

    logic [REG_WIDTH-1:0]     data_c_q;
    logic [CSR_OUT_WIDTH-1:0] csr_out_q;
    logic                     in_pending, out_valid, out_overrun, in_overwrite, irq_en;
    logic                     in_pending_n, out_valid_n, out_overrun_n, in_overwrite_n;
    logic                     timeout_flag, timeout_hit;
    logic                     wr_csr_in, wr_status, rd_csr_out;
    logic [4:0]               status;
    logic [REG_WIDTH-1:0]     rd_mux;

    assign wr_csr_in  = host_we && (host_addr == ADDR_CSR_IN);
    assign wr_status  = host_we && (host_addr == ADDR_STATUS);
    assign rd_csr_out = host_re && (host_addr == ADDR_CSR_OUT);
    assign status     = {timeout_flag, in_overwrite, out_overrun, out_valid, in_pending};

    // Flag updates: a new event in the same cycle beats a write-1-to-clear.
    always_comb begin
        in_pending_n   = in_pending;
        in_overwrite_n = in_overwrite & ~(wr_status & host_wdata[3]);
        out_valid_n    = out_valid;
        out_overrun_n  = out_overrun & ~(wr_status & host_wdata[2]);
        if (wr_csr_in) begin
            in_pending_n = 1'b1;
            if (in_pending && !csr_in_re) begin
                in_overwrite_n = 1'b1;
            end
        end else if (csr_in_re || timeout_hit) begin
            in_pending_n = 1'b0;
        end
        if (csr_out_we) begin
            out_valid_n = 1'b1;
            if (out_valid && !rd_csr_out) begin
                out_overrun_n = 1'b1;
            end
        end else if (rd_csr_out) begin
            out_valid_n = 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (host_addr)
            ADDR_DATA_A:  rd_mux = data_reg_a;
            ADDR_DATA_B:  rd_mux = data_reg_b;
            ADDR_DATA_C:  rd_mux = data_c_q;
            ADDR_CSR_IN:  rd_mux = REG_WIDTH'(csr_in);
            ADDR_CSR_OUT: rd_mux = REG_WIDTH'(csr_out_q);
            ADDR_STATUS:  rd_mux = REG_WIDTH'(status);
            ADDR_IRQ_EN:  rd_mux = REG_WIDTH'(irq_en);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_reg_a   <= '0;
            data_reg_b   <= '0;
            csr_in       <= '0;
            data_c_q     <= '0;
            csr_out_q    <= '0;
            irq_en       <= 1'b0;
            in_pending   <= 1'b0;
            in_overwrite <= 1'b0;
            out_valid    <= 1'b0;
            out_overrun  <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (host_we && host_addr == ADDR_DATA_A) data_reg_a <= host_wdata;
            if (host_we && host_addr == ADDR_DATA_B) data_reg_b <= host_wdata;
            if (wr_csr_in) csr_in <= host_wdata[CSR_IN_WIDTH-1:0];
            if (host_we && host_addr == ADDR_IRQ_EN) irq_en <= host_wdata[0];
            if (csr_out_we) begin
                data_c_q  <= data_reg_c;
                csr_out_q <= csr_out;
            end
            in_pending   <= in_pending_n;
            in_overwrite <= in_overwrite_n;
            out_valid    <= out_valid_n;
            out_overrun  <= out_overrun_n;
            host_rvalid  <= host_re;
            if (host_re) host_rdata <= rd_mux;
            irq          <= irq_en & (out_valid | out_overrun | in_overwrite | timeout_flag);
        end
    end

`ifdef IP_TILE_REGBANK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] pend_cnt;

    // Counter only runs while a command waits untouched; any write or consume restarts it.
    assign timeout_hit = in_pending && !wr_csr_in && !csr_in_re &&
                         (pend_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (wr_csr_in || csr_in_re || !in_pending || timeout_hit) begin
                pend_cnt <= '0;
            end else begin
                pend_cnt <= pend_cnt + 1'b1;
            end
            timeout_flag <= (timeout_flag & ~(wr_status & host_wdata[4])) | timeout_hit;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ip_tile_regbank.sv
// Randomized and directed bench for ip_tile_regbank against a behavioural register-map model.
// Define IP_TILE_REGBANK_TIMEOUT_EN to also exercise the pending-command timeout (TIMEOUT_CYCLES=8).
module tb_ip_tile_regbank;

    localparam int RW = 32;
    localparam int CIW = 16;
    localparam int COW = 16;
    localparam int AW = 3;
`ifdef IP_TILE_REGBANK_TIMEOUT_EN
    localparam int TC = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TC = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           arst_n;
    logic           host_we, host_re;
    logic [AW-1:0]  host_addr;
    logic [RW-1:0]  host_wdata, host_rdata;
    logic           host_rvalid;
    logic [RW-1:0]  data_reg_a, data_reg_b, data_reg_c;
    logic [CIW-1:0] csr_in;
    logic           csr_in_re;
    logic [COW-1:0] csr_out;
    logic           csr_out_we;
    logic           irq;

    ip_tile_regbank #(
        .REG_WIDTH(RW), .CSR_IN_WIDTH(CIW), .CSR_OUT_WIDTH(COW),
        .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .data_reg_a(data_reg_a), .data_reg_b(data_reg_b), .csr_in(csr_in),
        .csr_in_re(csr_in_re), .data_reg_c(data_reg_c), .csr_out(csr_out),
        .csr_out_we(csr_out_we), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the register map as the host sees it
    logic [RW-1:0]  m_a, m_b, m_c, m_rdata;
    logic [CIW-1:0] m_csr_in;
    logic [COW-1:0] m_csr_out;
    bit m_pend, m_valid, m_ovr, m_ow, m_to, m_irq_en, m_irq, m_rvalid;
    int m_age;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_c = '0; m_rdata = '0; m_csr_in = '0; m_csr_out = '0;
        m_pend = 0; m_valid = 0; m_ovr = 0; m_ow = 0; m_to = 0;
        m_irq_en = 0; m_irq = 0; m_rvalid = 0; m_age = 0;
    endtask

    function automatic logic [RW-1:0] model_read(input logic [AW-1:0] a);
        case (a)
            3'd0: return m_a;
            3'd1: return m_b;
            3'd2: return m_c;
            3'd3: return RW'(m_csr_in);
            3'd4: return RW'(m_csr_out);
            3'd5: return RW'({m_to, m_ow, m_ovr, m_valid, m_pend});
            3'd6: return RW'(m_irq_en);
            default: return '0;
        endcase
    endfunction

    // Advance one clock: model sees the driven inputs, DUT is sampled 1 time unit after the edge.
    task automatic tick();
        bit p_pend, p_valid, p_ovr, p_ow, p_to, p_en, rd_out;
        p_pend = m_pend; p_valid = m_valid; p_ovr = m_ovr; p_ow = m_ow; p_to = m_to; p_en = m_irq_en;
        rd_out = host_re && host_addr == 3'd4;
        m_rvalid = host_re;
        if (host_re) m_rdata = model_read(host_addr);
        m_irq = p_en & (p_valid | p_ovr | p_ow | p_to);
        if (host_we) begin
            case (host_addr)
                3'd0: m_a = host_wdata;
                3'd1: m_b = host_wdata;
                3'd3: m_csr_in = host_wdata[CIW-1:0];
                3'd5: begin
                    if (host_wdata[2]) m_ovr = 0;
                    if (host_wdata[3]) m_ow = 0;
                    if (host_wdata[4]) m_to = 0;
                end
                3'd6: m_irq_en = host_wdata[0];
                default: ;
            endcase
        end
        if (host_we && host_addr == 3'd3) begin
            if (p_pend && !csr_in_re) m_ow = 1;
            m_pend = 1;
            m_age = 0;
        end else if (csr_in_re && p_pend) begin
            m_pend = 0;
            m_age = 0;
        end else if (p_pend) begin
            if (TO_EN && m_age == TC - 1) begin
                m_pend = 0;
                m_to = 1;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
        if (csr_out_we) begin
            m_c = data_reg_c;
            m_csr_out = csr_out;
            if (p_valid && !rd_out) m_ovr = 1;
            m_valid = 1;
        end else if (rd_out) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("rvalid", RW'(host_rvalid), RW'(m_rvalid));
        if (m_rvalid) check("rdata", host_rdata, m_rdata);
        check("data_reg_a", data_reg_a, m_a);
        check("data_reg_b", data_reg_b, m_b);
        check("csr_in", RW'(csr_in), RW'(m_csr_in));
        check("irq", RW'(irq), RW'(m_irq));
    endtask

    task automatic idle();
        host_we = 0; host_re = 0; csr_in_re = 0; csr_out_we = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
        idle(); host_we = 1; host_addr = a; host_wdata = d;
        tick();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        idle(); host_re = 1; host_addr = a;
        tick();
        idle();
    endtask

    task automatic tile_out(input logic [RW-1:0] c, input logic [COW-1:0] s);
        idle(); csr_out_we = 1; data_reg_c = c; csr_out = s;
        tick();
        idle();
    endtask

    initial begin
        arst_n = 0; idle(); host_addr = '0; host_wdata = '0; data_reg_c = '0; csr_out = '0;
        model_reset();
        #2;
        check("rst_csr_in", RW'(csr_in), 0);
        check("rst_irq", RW'(irq), 0);
        check("rst_rvalid", RW'(host_rvalid), 0);
        #10 arst_n = 1;
        #4;

        for (int i = 0; i < 8; i++) begin
            rd(AW'(i));
            check("rst_read", host_rdata, 0);
        end
        tick();
        check("rvalid_drop", RW'(host_rvalid), 0);

        wr(3'd0, 32'hDEADBEEF);
        check("a_value", data_reg_a, 32'hDEADBEEF);
        wr(3'd1, 32'h12345678);
        wr(3'd3, 32'h0000_0005);
        check("csr_in_value", RW'(csr_in), 32'h5);
        rd(3'd5);
        check("status_pend", host_rdata, 32'h1);
        idle(); csr_in_re = 1; tick(); idle();
        rd(3'd5);
        check("status_consumed", host_rdata, 32'h0);

        wr(3'd3, 32'h1);
        wr(3'd3, 32'h2);
        check("csr_in_overwrite", RW'(csr_in), 32'h2);
        rd(3'd5);
        check("status_overwrite", host_rdata, 32'h9);
        wr(3'd5, 32'h8);
        rd(3'd5);
        check("status_w1c", host_rdata, 32'h1);
        // consume coinciding with a new command: stays pending, no overwrite
        idle(); csr_in_re = 1; host_we = 1; host_addr = 3'd3; host_wdata = 32'h33; tick(); idle();
        rd(3'd5);
        check("status_re_wr", host_rdata, 32'h1);
        idle(); csr_in_re = 1; tick(); idle();

        wr(3'd6, 32'h1);
        tile_out(32'hCAFEF00D, 16'h00A5);
        rd(3'd2);
        check("data_c", host_rdata, 32'hCAFEF00D);
        check("irq_set", RW'(irq), 1);
        rd(3'd4);
        check("csr_out", host_rdata, 32'h000000A5);
        tick();
        check("irq_clear", RW'(irq), 0);

        tile_out(32'h1111_1111, 16'h0001);
        tile_out(32'h2222_2222, 16'h0002);
        rd(3'd5);
        check("status_overrun", host_rdata, 32'h6);
        idle(); host_re = 1; host_addr = 3'd4; csr_out_we = 1;
        data_reg_c = 32'h3333_3333; csr_out = 16'h0003; tick(); idle();
        check("rd_vs_capture", host_rdata, 32'h2);
        rd(3'd5);
        check("valid_kept", host_rdata & 32'h2, 32'h2);
        wr(3'd5, 32'h1C);
        rd(3'd4);

`ifdef IP_TILE_REGBANK_TIMEOUT_EN
        wr(3'd3, 32'h7);
        for (int i = 0; i < 8; i++) tick();
        rd(3'd5);
        check("timeout_set", host_rdata, 32'h10);
        check("timeout_csr_in", RW'(csr_in), 32'h7);
        wr(3'd5, 32'h10);
        wr(3'd3, 32'h8);
        for (int i = 0; i < 4; i++) tick();
        idle(); csr_in_re = 1; tick(); idle();
        for (int i = 0; i < 10; i++) tick();
        rd(3'd5);
        check("timeout_none", host_rdata & 32'h10, 32'h0);
`endif

        for (int i = 0; i < 1500; i++) begin
            host_we    = ($urandom_range(0, 2) == 0);
            host_re    = ($urandom_range(0, 2) == 0);
            host_addr  = AW'($urandom_range(0, 7));
            host_wdata = $urandom;
            csr_in_re  = ($urandom_range(0, 3) == 0);
            csr_out_we = ($urandom_range(0, 3) == 0);
            data_reg_c = $urandom;
            csr_out    = COW'($urandom);
            tick();
        end
        idle();

        // reset in the middle of activity: command word must vanish without a clock
        wr(3'd3, 32'hBEEF);
        #3 arst_n = 0;
        #1;
        check("midrst_csr_in", RW'(csr_in), 0);
        check("midrst_a", data_reg_a, 0);
        check("midrst_irq", RW'(irq), 0);
        model_reset();
        #10 arst_n = 1;
        rd(3'd5);
        check("midrst_status", host_rdata, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
